// File: rtl/lsu_subword.sv
// lsu_subword: load/store unit between the core execute stage and a word-only dmem.
// Converts RV32I byte/halfword/word accesses into word-aligned dmem accesses.
// Loads are extended in the request cycle. SB/SH run as a read-modify-write
// over two cycles and stall the core for the read cycle.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned LH/LHU/SH/LW/SW raise fault and are suppressed
//   undefined -> alignment is not checked (halfword lane = addr[1], words ignore addr[1:0])
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/req_we  request strobe, 1 = store
//   funct3            RV32I width/sign field
//   addr, wdata       byte address, store data
//   rdata             extended load result
//   stall             core must hold PC/request this cycle
//   fault             request rejected, no memory access made
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata   dmem port (async read)
module lsu_subword #(
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RMW_WR = 1'b1
    } state_e;

    localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

    state_e      state_q, state_d;
    logic [31:0] mrg_q, mrg_d;
    logic [31:0] sav_addr_q, sav_addr_d;

    logic        funct3_ok;
    logic        range_err;
    logic        misalign_err;
    logic        req_fault;
    logic [31:0] word_addr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Request decode: legality, range and optional alignment checks
    always_comb begin
        funct3_ok    = 1'b0;
        misalign_err = 1'b0;
        if (req_we) begin
            funct3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            funct3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        range_err = (addr[31:2] >= DEPTH_W);
`ifdef LSU_MISALIGN_TRAP_EN
        case (funct3[1:0])
            2'b01:   misalign_err = addr[0];
            2'b10:   misalign_err = |addr[1:0];
            default: misalign_err = 1'b0;
        endcase
`else
        misalign_err = 1'b0;
`endif
        req_fault = !funct3_ok || range_err || misalign_err;
        word_addr = {addr[31:2], 2'b00};
    end

    // Lane selection, load extension and store merge
    always_comb begin
        case (addr[1:0])
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase

        merged = mem_rdata;
        if (funct3[0]) begin
            if (addr[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
        end else begin
            case (addr[1:0])
                2'b00:   merged[7:0]   = wdata[7:0];
                2'b01:   merged[15:8]  = wdata[7:0];
                2'b10:   merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end
    end

    // Next-state and dmem/core outputs; reset gates every output
    always_comb begin
        state_d    = state_q;
        mrg_d      = mrg_q;
        sav_addr_d = sav_addr_q;
        rdata      = 32'd0;
        stall      = 1'b0;
        fault      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (!rst && req_valid) begin
                    if (req_fault) begin
                        fault = 1'b1;
                    end else if (!req_we) begin
                        mem_read = 1'b1;
                        mem_addr = word_addr;
                        rdata    = load_data;
                    end else if (funct3 == 3'b010) begin
                        mem_write = 1'b1;
                        mem_addr  = word_addr;
                        mem_wdata = wdata;
                    end else begin
                        // Sub-word store read phase: capture merged word for next cycle
                        mem_read   = 1'b1;
                        stall      = 1'b1;
                        mem_addr   = word_addr;
                        mrg_d      = merged;
                        sav_addr_d = word_addr;
                        state_d    = S_RMW_WR;
                    end
                end
            end
            S_RMW_WR: begin
                if (!rst) begin
                    mem_write = 1'b1;
                    mem_addr  = sav_addr_q;
                    mem_wdata = mrg_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mrg_q      <= 32'd0;
            sav_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            mrg_q      <= mrg_d;
            sav_addr_q <= sav_addr_d;
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: dmem environment, transaction-level reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        stall, fault, mem_read, mem_write;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] dmem    [256];
    logic [31:0] ref_mem [256];
    logic        clr = 1'b0;
    logic        poke_en = 1'b0;
    int          poke_idx = 0;
    logic [31:0] poke_val = 32'd0;

    // Reference model state
    bit          m_pend = 1'b0, m_pend_n = 1'b0;
    logic [31:0] m_addr = 32'd0, m_addr_n = 32'd0;
    logic [31:0] m_word = 32'd0, m_word_n = 32'd0;
    bit          m_we_n = 1'b0;
    int          m_widx_n = 0;
    logic [31:0] m_wword_n = 32'd0;

    lsu_subword #(.MEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .fault     (fault),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr[9:2]];

    // Data memory seen by the DUT
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
        end else if (poke_en) begin
            dmem[poke_idx] <= poke_val;
        end else if (mem_write) begin
            dmem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluate expected outputs from the access rules, compare every cycle
    always @(negedge clk) begin : compare
        logic [31:0] e_rdata, e_maddr, e_mwdata, word, mask, val;
        logic        e_stall, e_fault, e_rd, e_wr;
        int          sz, sh, idx;
        bit          sgn, legal, flt;
        e_rdata = 0; e_maddr = 0; e_mwdata = 0;
        e_stall = 0; e_fault = 0; e_rd = 0; e_wr = 0;
        m_pend_n = 0; m_we_n = 0;
        sz = 4; sgn = 0; legal = 0;
        if (m_pend && rst) begin
            chk("cyc rst-in-write mem_write", 32'(mem_write), 32'd0);
            chk("cyc rst-in-write mem_read", 32'(mem_read), 32'd0);
        end else begin
            if (m_pend) begin
                e_wr = 1; e_maddr = m_addr; e_mwdata = m_word;
                m_we_n = 1; m_widx_n = int'(m_addr >> 2); m_wword_n = m_word;
            end else if (!rst && req_valid) begin
                case (funct3)
                    3'b000: begin sz = 1; sgn = 1; legal = 1; end
                    3'b001: begin sz = 2; sgn = 1; legal = 1; end
                    3'b010: begin sz = 4; sgn = 0; legal = 1; end
                    3'b100: begin sz = 1; sgn = 0; legal = !req_we; end
                    3'b101: begin sz = 2; sgn = 0; legal = !req_we; end
                    default: legal = 0;
                endcase
                flt = !legal || ((addr >> 2) >= 32'd256);
`ifdef LSU_MISALIGN_TRAP_EN
                if (legal && (addr % 32'(sz)) != 0) flt = 1;
`endif
                if (flt) begin
                    e_fault = 1;
                end else begin
                    idx     = int'(addr >> 2);
                    word    = ref_mem[idx];
                    e_maddr = addr & ~32'h3;
                    mask    = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
                    sh      = (sz == 1) ? int'(8 * (addr % 4)) : (sz == 2) ? int'(16 * ((addr / 2) % 2)) : 0;
                    if (!req_we) begin
                        e_rd = 1;
                        val  = (word >> sh) & mask;
                        if (sgn && sz < 4 && val[8*sz-1]) val = val | ~mask;
                        e_rdata = val;
                    end else if (sz == 4) begin
                        e_wr = 1; e_mwdata = wdata;
                        m_we_n = 1; m_widx_n = idx; m_wword_n = wdata;
                    end else begin
                        e_rd = 1; e_stall = 1; m_pend_n = 1;
                        m_addr_n = e_maddr;
                        m_word_n = (word & ~(mask << sh)) | ((wdata & mask) << sh);
                    end
                end
            end
            chk("cyc rdata", rdata, e_rdata);
            chk("cyc stall", 32'(stall), 32'(e_stall));
            chk("cyc fault", 32'(fault), 32'(e_fault));
            chk("cyc mem_read", 32'(mem_read), 32'(e_rd));
            chk("cyc mem_write", 32'(mem_write), 32'(e_wr));
            chk("cyc mem_addr", mem_addr, e_maddr);
            chk("cyc mem_wdata", mem_wdata, e_mwdata);
            chk("cyc rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
        end
    end

    always @(posedge clk) begin
        m_pend <= m_pend_n;
        m_addr <= m_addr_n;
        m_word <= m_word_n;
        if (clr) begin
            for (int i = 0; i < 256; i++) ref_mem[i] <= 32'd0;
        end else if (poke_en) begin
            ref_mem[poke_idx] <= poke_val;
        end else if (m_we_n) begin
            ref_mem[m_widx_n] <= m_wword_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        step();
        poke_en = 1'b0;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = d;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'd0);
        chk(name, rdata, exp);
        chk({name, " stall"}, 32'(stall), 32'd0);
        step();
    endtask

    int stalls;

    initial begin
        clr = 1'b1;
        step();
        clr = 1'b0;
        poke(4, 32'h8899AABB);
        poke(5, 32'h11223344);
        poke(6, 32'hCCDDEEFF);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        rst = 1'b0;
        step();

        // Loads with sign/zero extension
        load_chk("lb 0x11", 3'b000, 32'h11, 32'hFFFFFFAA);
        load_chk("lbu 0x11", 3'b100, 32'h11, 32'h000000AA);
        load_chk("lh 0x12", 3'b001, 32'h12, 32'hFFFF8899);
        load_chk("lhu 0x12", 3'b101, 32'h12, 32'h00008899);
        load_chk("lb 0x10", 3'b000, 32'h10, 32'hFFFFFFBB);
        load_chk("lbu 0x13", 3'b100, 32'h13, 32'h00000088);
        load_chk("lh 0x14", 3'b001, 32'h14, 32'h00003344);
        load_chk("lw 0x10", 3'b010, 32'h10, 32'h8899AABB);

        // SB read-modify-write then back-to-back loads
        drive(1'b1, 1'b1, 3'b000, 32'h12, 32'h12345677);
        chk("sb read stall", 32'(stall), 32'd1);
        chk("sb read mem_read", 32'(mem_read), 32'd1);
        step();
        chk("sb write mem_write", 32'(mem_write), 32'd1);
        chk("sb write mem_wdata", mem_wdata, 32'h8877AABB);
        chk("sb write mem_addr", mem_addr, 32'h10);
        chk("sb write stall", 32'(stall), 32'd0);
        step();
        load_chk("lb after sb", 3'b000, 32'h12, 32'h00000077);
        load_chk("lw after sb", 3'b010, 32'h10, 32'h8877AABB);
        idle();
        chk("dmem4 after sb", dmem[4], 32'h8877AABB);
        chk("ref4 after sb", ref_mem[4], 32'h8877AABB);

        // SH then SW: one stall cycle total
        poke(4, 32'h8899AABB);
        stalls = 0;
        drive(1'b1, 1'b1, 3'b001, 32'h10, 32'h0000CAFE);
        if (stall) stalls++;
        step();
        if (stall) stalls++;
        step();
        drive(1'b1, 1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
        if (stall) stalls++;
        chk("sw mem_write", 32'(mem_write), 32'd1);
        step();
        idle();
        step();
        chk("sh+sw stall cycles", 32'(stalls), 32'd1);
        chk("dmem4 after sh", dmem[4], 32'h8899CAFE);
        chk("dmem5 after sw", dmem[5], 32'hDEADBEEF);
        chk("ref5 after sw", ref_mem[5], 32'hDEADBEEF);

        // Faults
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'd0);
        chk("lw 0x400 fault", 32'(fault), 32'd1);
        chk("lw 0x400 mem_read", 32'(mem_read), 32'd0);
        chk("lw 0x400 rdata", rdata, 32'd0);
        step();
        drive(1'b1, 1'b0, 3'b011, 32'h10, 32'd0);
        chk("load f3=011 fault", 32'(fault), 32'd1);
        step();
        drive(1'b1, 1'b1, 3'b100, 32'h10, 32'h5);
        chk("store f3=100 fault", 32'(fault), 32'd1);
        chk("store f3=100 mem_write", 32'(mem_write), 32'd0);
        step();
`ifdef LSU_MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 3'b010, 32'h13, 32'd0);
        chk("lw 0x13 fault", 32'(fault), 32'd1);
        step();
        drive(1'b1, 1'b1, 3'b001, 32'h11, 32'h1111);
        chk("sh 0x11 fault", 32'(fault), 32'd1);
        chk("sh 0x11 mem_read", 32'(mem_read), 32'd0);
        step();
        idle();
        #1;
        chk("sh 0x11 no write", 32'(mem_write), 32'd0);
        step();
        chk("dmem4 after sh 0x11", dmem[4], 32'h8899CAFE);
`else
        drive(1'b1, 1'b0, 3'b010, 32'h13, 32'd0);
        chk("lw 0x13 fault", 32'(fault), 32'd0);
        chk("lw 0x13 rdata", rdata, 32'h8899CAFE);
        step();
`endif

        // Reset during the write phase suppresses the write
        drive(1'b1, 1'b1, 3'b000, 32'h18, 32'h00000055);
        chk("sb2 read stall", 32'(stall), 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("rst in write mem_write", 32'(mem_write), 32'd0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("post-rst mem_write", 32'(mem_write), 32'd0);
        chk("post-rst stall", 32'(stall), 32'd0);
        chk("post-rst rdata", rdata, 32'd0);
        step();
        chk("dmem6 unchanged", dmem[6], 32'hCCDDEEFF);
        load_chk("lw 0x18 after rst", 3'b010, 32'h18, 32'hCCDDEEFF);
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
